axi_lite_cut: RTL and testbench

- Register slice for AXI-Lite, placed directly upstream of the interface join between a master port and the interconnect.
- Breaks every combinational path (valid, payload and ready) on all five channels AW, W, B, AR and R with one two-entry spill register per channel.
- Sustains full throughput; an optional bypass turns the block into plain wires.

---
 rtl/axi_lite_cut.sv | 138 +++++++++++++
 tb/tb_axi_lite_cut.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_cut.sv
// axi_lite_cut: AXI-Lite register slice cutting valid, ready and payload on all five channels.
// Each channel goes through a two-slot spill register; Bypass=1 reduces the block to wires.
package axi_lite_cut_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } aw_chan_t;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } w_chan_t;
    typedef struct packed {
        logic [1:0] resp;
    } b_chan_t;
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } ar_chan_t;
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_chan_t;
    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;
    typedef struct packed {
        logic     aw_ready;
        logic     w_ready;
        b_chan_t  b;
        logic     b_valid;
        logic     ar_ready;
        r_chan_t  r;
        logic     r_valid;
    } resp_t;
endpackage

module axi_lite_cut_spill #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);
    T     a, b;
    logic a_full, b_full;
    logic in_hs, out_hs;

    assign in_ready  = !b_full;
    assign out_valid = a_full;
    assign out_data  = a;
    assign in_hs     = in_valid && !b_full;
    assign out_hs    = a_full && out_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a      <= '0;
            b      <= '0;
            a_full <= 1'b0;
            b_full <= 1'b0;
        end else if (out_hs && b_full) begin
            a      <= b;
            b_full <= 1'b0;
        end else if (in_hs && (!a_full || out_hs)) begin
            a      <= in_data;
            a_full <= 1'b1;
        end else if (in_hs) begin
            b      <= in_data;
            b_full <= 1'b1;
        end else if (out_hs) begin
            a_full <= 1'b0;
        end
    end

    // upstream must hold valid and payload until the beat is taken
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        in_valid && !in_ready |=> in_valid && $stable(in_data));
endmodule

module axi_lite_cut #(
    parameter bit  Bypass    = 1'b0,
    parameter type aw_chan_t = axi_lite_cut_pkg::aw_chan_t,
    parameter type w_chan_t  = axi_lite_cut_pkg::w_chan_t,
    parameter type b_chan_t  = axi_lite_cut_pkg::b_chan_t,
    parameter type ar_chan_t = axi_lite_cut_pkg::ar_chan_t,
    parameter type r_chan_t  = axi_lite_cut_pkg::r_chan_t,
    parameter type req_t     = axi_lite_cut_pkg::req_t,
    parameter type resp_t    = axi_lite_cut_pkg::resp_t
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  req_t  slv_req_i,
    output resp_t slv_resp_o,
    output req_t  mst_req_o,
    input  resp_t mst_resp_i
);
    if (Bypass) begin : g_bypass
        assign mst_req_o  = slv_req_i;
        assign slv_resp_o = mst_resp_i;
    end else begin : g_cut
        axi_lite_cut_spill #(.T(aw_chan_t)) u_aw (
            .clk_i(clk_i), .rst_ni(rst_ni),
            .in_valid(slv_req_i.aw_valid), .in_ready(slv_resp_o.aw_ready), .in_data(slv_req_i.aw),
            .out_valid(mst_req_o.aw_valid), .out_ready(mst_resp_i.aw_ready), .out_data(mst_req_o.aw)
        );
        axi_lite_cut_spill #(.T(w_chan_t)) u_w (
            .clk_i(clk_i), .rst_ni(rst_ni),
            .in_valid(slv_req_i.w_valid), .in_ready(slv_resp_o.w_ready), .in_data(slv_req_i.w),
            .out_valid(mst_req_o.w_valid), .out_ready(mst_resp_i.w_ready), .out_data(mst_req_o.w)
        );
        axi_lite_cut_spill #(.T(b_chan_t)) u_b (
            .clk_i(clk_i), .rst_ni(rst_ni),
            .in_valid(mst_resp_i.b_valid), .in_ready(mst_req_o.b_ready), .in_data(mst_resp_i.b),
            .out_valid(slv_resp_o.b_valid), .out_ready(slv_req_i.b_ready), .out_data(slv_resp_o.b)
        );
        axi_lite_cut_spill #(.T(ar_chan_t)) u_ar (
            .clk_i(clk_i), .rst_ni(rst_ni),
            .in_valid(slv_req_i.ar_valid), .in_ready(slv_resp_o.ar_ready), .in_data(slv_req_i.ar),
            .out_valid(mst_req_o.ar_valid), .out_ready(mst_resp_i.ar_ready), .out_data(mst_req_o.ar)
        );
        axi_lite_cut_spill #(.T(r_chan_t)) u_r (
            .clk_i(clk_i), .rst_ni(rst_ni),
            .in_valid(mst_resp_i.r_valid), .in_ready(mst_req_o.r_ready), .in_data(mst_resp_i.r),
            .out_valid(slv_resp_o.r_valid), .out_ready(slv_req_i.r_ready), .out_data(slv_resp_o.r)
        );
    end
endmodule

// File: tb/tb_axi_lite_cut.sv
// tb_axi_lite_cut: directed bench for the AXI-Lite register slice, cut and bypass builds.
module tb_axi_lite_cut;
    import axi_lite_cut_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    req_t  slv_req;
    resp_t mst_resp;
    req_t  mst_req, byp_mst_req;
    resp_t slv_resp, byp_slv_resp;
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    axi_lite_cut #(.Bypass(1'b0)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .slv_req_i(slv_req), .slv_resp_o(slv_resp),
        .mst_req_o(mst_req), .mst_resp_i(mst_resp)
    );

    axi_lite_cut #(.Bypass(1'b1)) byp (
        .clk_i(clk), .rst_ni(rst_n),
        .slv_req_i(slv_req), .slv_resp_o(byp_slv_resp),
        .mst_req_o(byp_mst_req), .mst_resp_i(mst_resp)
    );

    task automatic drive_slot();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        slv_req  = '0;
        mst_resp = '0;
        rst_n    = 1'b0;
        slv_req.aw_valid = 1'b1;
        slv_req.aw.addr  = 32'h1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (mst_req.aw_valid !== 1'b0) begin errors++; $display("FAIL rst_aw_valid got=%b want=0", mst_req.aw_valid); end
        checks++; if (mst_req.w_valid !== 1'b0) begin errors++; $display("FAIL rst_w_valid got=%b want=0", mst_req.w_valid); end
        checks++; if (mst_req.ar_valid !== 1'b0) begin errors++; $display("FAIL rst_ar_valid got=%b want=0", mst_req.ar_valid); end
        checks++; if (slv_resp.b_valid !== 1'b0) begin errors++; $display("FAIL rst_b_valid got=%b want=0", slv_resp.b_valid); end
        checks++; if (slv_resp.r_valid !== 1'b0) begin errors++; $display("FAIL rst_r_valid got=%b want=0", slv_resp.r_valid); end
        rst_n = 1'b1;
        slv_req.aw_valid = 1'b0;
        #1;
        checks++; if (slv_resp.aw_ready !== 1'b1) begin errors++; $display("FAIL rst_aw_ready got=%b want=1", slv_resp.aw_ready); end
        checks++; if (slv_resp.w_ready !== 1'b1) begin errors++; $display("FAIL rst_w_ready got=%b want=1", slv_resp.w_ready); end
        checks++; if (slv_resp.ar_ready !== 1'b1) begin errors++; $display("FAIL rst_ar_ready got=%b want=1", slv_resp.ar_ready); end
        checks++; if (mst_req.b_ready !== 1'b1) begin errors++; $display("FAIL rst_b_ready got=%b want=1", mst_req.b_ready); end
        checks++; if (mst_req.r_ready !== 1'b1) begin errors++; $display("FAIL rst_r_ready got=%b want=1", mst_req.r_ready); end
        checks++; if (mst_req.aw !== '0) begin errors++; $display("FAIL rst_aw_payload got=%h want=0", mst_req.aw); end
    endtask

    task automatic test_single_write();
        drive_slot();
        mst_resp.aw_ready = 1'b1;
        mst_resp.w_ready  = 1'b1;
        slv_req.b_ready   = 1'b1;
        slv_req.aw_valid  = 1'b1;
        slv_req.aw.addr   = 32'h40;
        slv_req.aw.prot   = 3'h0;
        slv_req.w_valid   = 1'b1;
        slv_req.w.data    = 32'hDEADBEEF;
        slv_req.w.strb    = 4'hF;
        @(negedge clk);
        checks++; if (mst_req.aw_valid !== 1'b0) begin errors++; $display("FAIL wr_aw_early got=%b want=0", mst_req.aw_valid); end
        drive_slot();
        slv_req.aw_valid = 1'b0;
        slv_req.w_valid  = 1'b0;
        slv_req.aw.addr  = 32'h0;
        slv_req.w.data   = 32'h0;
        @(negedge clk);
        checks++; if (mst_req.aw_valid !== 1'b1) begin errors++; $display("FAIL wr_aw_valid got=%b want=1", mst_req.aw_valid); end
        checks++; if (mst_req.aw.addr !== 32'h40 || mst_req.aw.prot !== 3'h0) begin errors++; $display("FAIL wr_aw_payload got=%h want=40/0", mst_req.aw); end
        checks++; if (mst_req.w_valid !== 1'b1) begin errors++; $display("FAIL wr_w_valid got=%b want=1", mst_req.w_valid); end
        checks++; if (mst_req.w.data !== 32'hDEADBEEF || mst_req.w.strb !== 4'hF) begin errors++; $display("FAIL wr_w_payload got=%h want=deadbeef/f", mst_req.w); end
        drive_slot();
        @(negedge clk);
        checks++; if (mst_req.aw_valid !== 1'b0 || mst_req.w_valid !== 1'b0) begin errors++; $display("FAIL wr_one_cycle got=%b%b want=00", mst_req.aw_valid, mst_req.w_valid); end
        mst_resp.b_valid = 1'b1;
        mst_resp.b.resp  = 2'b00;
        #1;
        checks++; if (slv_resp.b_valid !== 1'b0) begin errors++; $display("FAIL wr_b_early got=%b want=0", slv_resp.b_valid); end
        drive_slot();
        mst_resp.b_valid = 1'b0;
        mst_resp.b.resp  = 2'b11;
        @(negedge clk);
        checks++; if (slv_resp.b_valid !== 1'b1 || slv_resp.b.resp !== 2'b00) begin errors++; $display("FAIL wr_b_resp got=%b/%b want=1/00", slv_resp.b_valid, slv_resp.b.resp); end
        drive_slot();
        @(negedge clk);
        checks++; if (slv_resp.b_valid !== 1'b0) begin errors++; $display("FAIL wr_b_drain got=%b want=0", slv_resp.b_valid); end
    endtask

    task automatic test_back_pressure();
        drive_slot();
        mst_resp.ar_ready = 1'b0;
        slv_req.ar_valid  = 1'b1;
        slv_req.ar.addr   = 32'h0;
        drive_slot();
        slv_req.ar.addr = 32'h4;
        drive_slot();
        slv_req.ar.addr = 32'h8;
        @(negedge clk);
        checks++; if (slv_resp.ar_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_drop got=%b want=0", slv_resp.ar_ready); end
        checks++; if (mst_req.ar_valid !== 1'b1 || mst_req.ar.addr !== 32'h0) begin errors++; $display("FAIL bp_head got=%b/%h want=1/0", mst_req.ar_valid, mst_req.ar.addr); end
        drive_slot();
        mst_resp.ar_ready = 1'b1;
        @(negedge clk);
        checks++; if (slv_resp.ar_ready !== 1'b0 || mst_req.ar.addr !== 32'h0) begin errors++; $display("FAIL bp_hold got=%b/%h want=0/0", slv_resp.ar_ready, mst_req.ar.addr); end
        drive_slot();
        @(negedge clk);
        checks++; if (mst_req.ar_valid !== 1'b1 || mst_req.ar.addr !== 32'h4) begin errors++; $display("FAIL bp_second got=%b/%h want=1/4", mst_req.ar_valid, mst_req.ar.addr); end
        checks++; if (slv_resp.ar_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got=%b want=1", slv_resp.ar_ready); end
        drive_slot();
        slv_req.ar_valid = 1'b0;
        @(negedge clk);
        checks++; if (mst_req.ar_valid !== 1'b1 || mst_req.ar.addr !== 32'h8) begin errors++; $display("FAIL bp_third got=%b/%h want=1/8", mst_req.ar_valid, mst_req.ar.addr); end
        drive_slot();
        @(negedge clk);
        checks++; if (mst_req.ar_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b want=0", mst_req.ar_valid); end
    endtask

    task automatic test_throughput();
        drive_slot();
        slv_req.r_ready  = 1'b1;
        mst_resp.r_valid = 1'b1;
        mst_resp.r.data  = 32'h1000_0000;
        mst_resp.r.resp  = 2'd0;
        for (int i = 0; i < 16; i++) begin
            drive_slot();
            if (i < 15) begin
                mst_resp.r.data = 32'h1000_0000 + 32'(3 * (i + 1));
                mst_resp.r.resp = 2'(i + 1);
            end else begin
                mst_resp.r_valid = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (slv_resp.r_valid !== 1'b1 || slv_resp.r.data !== 32'h1000_0000 + 32'(3 * i) || slv_resp.r.resp !== 2'(i) || mst_req.r_ready !== 1'b1) begin
                errors++;
                $display("FAIL tp_beat%0d got=%b/%h/%h rdy=%b want=1/%h/%h rdy=1", i, slv_resp.r_valid, slv_resp.r.data, slv_resp.r.resp, mst_req.r_ready, 32'h1000_0000 + 32'(3 * i), 2'(i));
            end
        end
        drive_slot();
        @(negedge clk);
        checks++; if (slv_resp.r_valid !== 1'b0) begin errors++; $display("FAIL tp_drain got=%b want=0", slv_resp.r_valid); end
    endtask

    task automatic test_reset_mid();
        drive_slot();
        mst_resp.w_ready = 1'b0;
        slv_req.w_valid  = 1'b1;
        slv_req.w.data   = 32'hAAAA_0001;
        slv_req.w.strb   = 4'h3;
        drive_slot();
        slv_req.w.data = 32'hAAAA_0002;
        drive_slot();
        slv_req.w_valid = 1'b0;
        @(negedge clk);
        checks++; if (mst_req.w_valid !== 1'b1 || slv_resp.w_ready !== 1'b0) begin errors++; $display("FAIL rm_full got=%b/%b want=1/0", mst_req.w_valid, slv_resp.w_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (mst_req.w_valid !== 1'b0) begin errors++; $display("FAIL rm_async_valid got=%b want=0", mst_req.w_valid); end
        checks++; if (mst_req.w !== '0 || slv_resp.w_ready !== 1'b1) begin errors++; $display("FAIL rm_async_clear got=%h/%b want=0/1", mst_req.w, slv_resp.w_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        mst_resp.w_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_slot();
            @(negedge clk);
            checks++; if (mst_req.w_valid !== 1'b0) begin errors++; $display("FAIL rm_stale%0d got=%b want=0", i, mst_req.w_valid); end
        end
    endtask

    task automatic test_bypass();
        drive_slot();
        mst_resp = '0;
        mst_resp.aw_ready = 1'b1;
        mst_resp.w_ready  = 1'b1;
        slv_req = '0;
        slv_req.b_ready  = 1'b1;
        @(negedge clk);
        slv_req.aw_valid = 1'b1;
        slv_req.aw.addr  = 32'h40;
        slv_req.w_valid  = 1'b1;
        slv_req.w.data   = 32'hDEADBEEF;
        slv_req.w.strb   = 4'hF;
        #1;
        checks++; if (byp_mst_req.aw_valid !== 1'b1 || byp_mst_req.aw.addr !== 32'h40) begin errors++; $display("FAIL byp_aw got=%b/%h want=1/40", byp_mst_req.aw_valid, byp_mst_req.aw.addr); end
        checks++; if (byp_mst_req.w_valid !== 1'b1 || byp_mst_req.w.data !== 32'hDEADBEEF || byp_mst_req.w.strb !== 4'hF) begin errors++; $display("FAIL byp_w got=%b/%h want=1/deadbeef", byp_mst_req.w_valid, byp_mst_req.w); end
        checks++; if (byp_mst_req.b_ready !== 1'b1 || byp_slv_resp.aw_ready !== 1'b1) begin errors++; $display("FAIL byp_ready got=%b/%b want=1/1", byp_mst_req.b_ready, byp_slv_resp.aw_ready); end
        mst_resp.b_valid = 1'b1;
        mst_resp.b.resp  = 2'b10;
        rst_n = 1'b0;
        #1;
        checks++; if (byp_slv_resp.b_valid !== 1'b1 || byp_slv_resp.b.resp !== 2'b10) begin errors++; $display("FAIL byp_b got=%b/%b want=1/10", byp_slv_resp.b_valid, byp_slv_resp.b.resp); end
        checks++; if (byp_mst_req.aw_valid !== 1'b1) begin errors++; $display("FAIL byp_reset got=%b want=1", byp_mst_req.aw_valid); end
        #1;
        rst_n = 1'b1;
        slv_req  = '0;
        mst_resp = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_write();
        test_back_pressure();
        test_throughput();
        test_reset_mid();
        test_bypass();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
